// File: rtl/sd_pkg.sv
// Shared definitions for the SD request arbiter: controller command codes,
// arbiter FSM encoding and the default timeout status byte.
package sd_pkg;

   localparam logic [7:0] CTRL_NOP   = 8'd0;
   localparam logic [7:0] CTRL_READ  = 8'd1;
   localparam logic [7:0] CTRL_WRITE = 8'd2;

   localparam logic [7:0] TIMEOUT_STATUS_DEFAULT = 8'hFF;

   localparam int CNT_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   function automatic logic [7:0] op_code(input logic wr);
      return wr ? CTRL_WRITE : CTRL_READ;
   endfunction

endpackage

// File: rtl/sd_rr_arbiter.sv
// Combinational 2-way round-robin picker: a lone requester wins, and on a tie
// the port that was not served last wins. Zero latency, no backpressure.
module sd_rr_arbiter (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant,
   output logic       grant_idx
);

   always_comb begin
      grant_idx = 1'b0;
      grant     = 2'b00;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last;
         default: grant_idx = 1'b0;
      endcase
      if (|req) begin
         grant = grant_idx ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/sd_request_arbiter.sv
// Shares one sd_card_controller between two sector requesters; ack one cycle after
// a request is seen, command held until status strobe or watchdog, requests ignored while busy.
module sd_request_arbiter
   import sd_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter logic [7:0]  TIMEOUT_STATUS = TIMEOUT_STATUS_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req0,
   input  logic        i_wr0,
   input  logic [31:0] i_addr0,
   output logic        o_ack0,
   output logic        o_done0,
   input  logic        i_req1,
   input  logic        i_wr1,
   input  logic [31:0] i_addr1,
   output logic        o_ack1,
   output logic        o_done1,
   output logic [7:0]  o_status,
   output logic        o_busy,
   output logic        o_owner,
   output logic [31:0] o_addr,
   output logic [7:0]  o_controlreg,
   input  logic [7:0]  i_statusreg,
   input  logic        i_write_statusreg
);

   localparam int unsigned GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] GAP_LAST = GAP_M1[CNT_W-1:0];

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             last_q, last_d;
   logic             owner_d;
   logic [31:0]      addr_d;
   logic [7:0]       ctrl_d, status_d;
   logic [1:0]       ack_d, done_d;
   logic [1:0]       grant;
   logic             grant_idx;

   sd_rr_arbiter u_rr (
      .req       ({i_req1, i_req0}),
      .last      (last_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // One counter serves both the watchdog (ISSUE) and the NOP gap (GAP).
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      owner_d  = o_owner;
      addr_d   = o_addr;
      ctrl_d   = o_controlreg;
      status_d = o_status;
      ack_d    = 2'b00;
      done_d   = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (i_req0 || i_req1) begin
               owner_d = grant_idx;
               ack_d   = grant;
               addr_d  = grant_idx ? i_addr1 : i_addr0;
               ctrl_d  = op_code(grant_idx ? i_wr1 : i_wr0);
               cnt_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d = cnt_inc;
            // The strobe is checked first so a real status beats a same-cycle timeout.
            if (i_write_statusreg) begin
               status_d = i_statusreg;
               ctrl_d   = CTRL_NOP;
               done_d   = o_owner ? 2'b10 : 2'b01;
               state_d  = ST_DONE;
            end else if (cnt_inc >= TIMEOUT_CYCLES) begin
               status_d = TIMEOUT_STATUS;
               ctrl_d   = CTRL_NOP;
               done_d   = o_owner ? 2'b10 : 2'b01;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            last_d  = o_owner;
            cnt_d   = '0;
            state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_q       <= 1'b1;
         o_owner      <= 1'b0;
         o_addr       <= '0;
         o_controlreg <= CTRL_NOP;
         o_status     <= '0;
         o_ack0       <= 1'b0;
         o_ack1       <= 1'b0;
         o_done0      <= 1'b0;
         o_done1      <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         o_owner      <= owner_d;
         o_addr       <= addr_d;
         o_controlreg <= ctrl_d;
         o_status     <= status_d;
         o_ack0       <= ack_d[0];
         o_ack1       <= ack_d[1];
         o_done0      <= done_d[0];
         o_done1      <= done_d[1];
         o_busy       <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_sd_request_arbiter.sv
// Directed plus randomized bench for sd_request_arbiter, checked against a
// transaction-level model of grant order, completion time and status.
module tb_sd_request_arbiter;

   localparam int T   = 100;
   localparam int GAP = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_req0 = 1'b0, i_wr0 = 1'b0, i_req1 = 1'b0, i_wr1 = 1'b0;
   logic [31:0] i_addr0 = '0, i_addr1 = '0;
   logic [7:0]  i_statusreg = '0;
   logic        i_write_statusreg = 1'b0;
   logic        o_ack0, o_done0, o_ack1, o_done1, o_busy, o_owner;
   logic [7:0]  o_status, o_controlreg;
   logic [31:0] o_addr;

   int errors = 0;
   int checks = 0;
   int last_served = 1;
   logic [7:0] last_status = 8'h00;

   always #5 i_clk = ~i_clk;

   sd_request_arbiter #(
      .TIMEOUT_CYCLES (24'd100),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_STATUS (8'hFF)
   ) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_req0            (i_req0),
      .i_wr0             (i_wr0),
      .i_addr0           (i_addr0),
      .o_ack0            (o_ack0),
      .o_done0           (o_done0),
      .i_req1            (i_req1),
      .i_wr1             (i_wr1),
      .i_addr1           (i_addr1),
      .o_ack1            (o_ack1),
      .o_done1           (o_done1),
      .o_status          (o_status),
      .o_busy            (o_busy),
      .o_owner           (o_owner),
      .o_addr            (o_addr),
      .o_controlreg      (o_controlreg),
      .i_statusreg       (i_statusreg),
      .i_write_statusreg (i_write_statusreg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge i_clk);
   endtask

   task automatic do_reset(input string tag);
      i_rst_n = 1'b0;
      i_req0 = 1'b0; i_req1 = 1'b0; i_write_statusreg = 1'b0;
      #1;
      chk({tag, " ctrl"},  32'(o_controlreg), 32'h0);
      chk({tag, " addr"},  o_addr, 32'h0);
      chk({tag, " status"}, 32'(o_status), 32'h0);
      chk({tag, " owner"}, 32'(o_owner), 32'h0);
      chk({tag, " pulses"}, 32'({o_ack1, o_ack0, o_done1, o_done0, o_busy}), 32'h0);
      step();
      step();
      i_rst_n = 1'b1;
      last_served = 1;
      last_status = 8'h00;
   endtask

   // k = index of the command cycle carrying the strobe; k >= T means no strobe.
   task automatic run_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input int k, input logic [7:0] sv, input string tag);
      int w;
      int off;
      logic [7:0] st;
      logic [7:0] code;
      logic [31:0] ad;
      w    = (r0 && r1) ? 1 - last_served : (r1 ? 1 : 0);
      off  = (k < T) ? k + 1 : T;
      st   = (k < T) ? sv : 8'hFF;
      code = ((w == 1) ? w1 : w0) ? 8'd2 : 8'd1;
      ad   = (w == 1) ? a1 : a0;
      i_req0 = r0; i_req1 = r1; i_wr0 = w0; i_wr1 = w1; i_addr0 = a0; i_addr1 = a1;
      step();
      chk({tag, " ack"}, 32'({o_ack1, o_ack0}), (w == 1) ? 32'h2 : 32'h1);
      chk({tag, " cmd"}, 32'(o_controlreg), 32'(code));
      chk({tag, " addr"}, o_addr, ad);
      chk({tag, " owner/busy"}, 32'({o_owner, o_busy}), 32'({w[0], 1'b1}));
      if (w == 1) i_req1 = 1'b0; else i_req0 = 1'b0;
      for (int i = 1; i <= off; i++) begin
         i_write_statusreg = (i - 1 == k);
         i_statusreg = (i - 1 == k) ? sv : 8'($urandom);
         step();
         if (i < off)
            chk({tag, " hold"}, 32'({o_done1, o_done0, o_ack1, o_ack0, o_controlreg}), 32'(code));
      end
      chk({tag, " done"}, 32'({o_done1, o_done0}), (w == 1) ? 32'h2 : 32'h1);
      chk({tag, " status"}, 32'(o_status), 32'(st));
      chk({tag, " nop"}, 32'(o_controlreg), 32'h0);
      for (int g = 0; g < GAP; g++) begin
         i_write_statusreg = 1'($urandom_range(0, 1));
         i_statusreg = 8'($urandom);
         step();
         chk({tag, " gap"}, 32'({o_done1, o_done0, o_ack1, o_ack0, o_busy, o_status, o_controlreg}),
             32'({4'b0000, 1'b1, st, 8'h00}));
      end
      i_write_statusreg = 1'b0;
      step();
      chk({tag, " idle"}, 32'({o_busy, o_status}), 32'({1'b0, st}));
      last_served = w;
      last_status = st;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      do_reset("reset");

      // Single read, strobe on the 50th command cycle.
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 49, 8'h00, "single_read");

      // Contention from reset: 0,1,0,1.
      do_reset("reset2");
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
                 10, 8'(i + 1), "contention");
         chk("rr order", 32'(o_owner), 32'(i % 2));
      end

      run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0777, T + 3, 8'h00, "timeout");
      run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0555, 32'h0, T - 1, 8'h05, "strobe_at_timeout");

      // Stray strobe while idle.
      i_write_statusreg = 1'b1; i_statusreg = 8'h33;
      step();
      i_write_statusreg = 1'b0;
      step();
      chk("stray strobe", 32'({o_done1, o_done0, o_busy, o_status}), 32'({3'b000, last_status}));

      // Reset in the middle of a read.
      i_req0 = 1'b1; i_wr0 = 1'b0; i_addr0 = 32'h0000_1234;
      step();
      chk("mid ack", 32'({o_ack1, o_ack0, o_controlreg}), 32'({2'b01, 8'h01}));
      i_req0 = 1'b0;
      step();
      step();
      #2;
      do_reset("mid_reset");
      run_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_4321, 5, 8'h5A, "after_reset");

      // Randomized traffic against the model.
      for (int n = 0; n < 24; n++) begin
         int pat;
         int k;
         pat = $urandom_range(1, 3);
         k = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 5) : $urandom_range(0, 20);
         run_txn(pat[0], pat[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
                 k, 8'($urandom), "random");
      end

      // A request withdrawn before it is sampled in IDLE is never acked.
      i_req0 = 1'b0; i_req1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("withdrawn", 32'({o_ack1, o_ack0, o_busy}), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sd_request_arbiter.md
Name: sd_request_arbiter

Overview:
Shares the single sd_card_controller between two block-level requesters: port 0 is the CPU/bus and port 1 is the VGA/asset loader. Each request is one 512-byte sector read or write. The block latches the requester's sector address and operation, then drives i_addr/i_controlreg of sd_card_controller. It holds the command until the controller's status-write strobe arrives, returns the status byte to the owning requester, and enforces a watchdog timeout. It sits between the bus/loader logic and sd_card_controller; the buffer-memory port is not arbitrated here.

Parameters:
TIMEOUT_CYCLES, 24'd2_000_000, max i_clk cycles to wait for the status strobe before aborting; must be ≥ 1.
GAP_CYCLES, 4, NOP cycles forced on o_controlreg between consecutive commands; 0 is legal.
TIMEOUT_STATUS, 8'hFF, status byte reported on timeout.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req0  in  1  requester 0 request; level, held until o_ack0
i_wr0  in  1  requester 0 op: 1=write sector, 0=read sector
i_addr0  in  32  requester 0 sector address
o_ack0  out  1  1-cycle pulse: request 0 accepted, inputs latched
o_done0  out  1  1-cycle pulse: request 0 finished, o_status valid
i_req1, i_wr1, i_addr1, o_ack1, o_done1: same as port 0, for requester 1
o_status  out  8  status of the last completed command; held until the next completion
o_busy  out  1  high whenever state != IDLE
o_owner  out  1  index of the requester currently or last served
o_addr  out  32  to sd_card_controller i_addr
o_controlreg  out  8  to sd_card_controller i_controlreg; codes: 0 = NOP, 1 = READ, 2 = WRITE
i_statusreg  in  8  from sd_card_controller o_statusreg
i_write_statusreg  in  1  from sd_card_controller o_write_statusreg; synchronous to i_clk; ends the command

Behaviour:
- Reset (async, i_rst_n=0) forces:
  - state=IDLE
  - o_controlreg=NOP, o_addr=0, o_status=0, o_owner=0
  - all ack/done pulses=0, o_busy=0
  - round-robin pointer prefers port 0
  - timeout and gap counters = 0
  - Reset mid-command drops the command silently: no done pulse, o_controlreg=NOP immediately.
- All outputs are registered.
- States: IDLE -> ISSUE -> DONE -> GAP -> IDLE.
- IDLE:
  - If any i_reqN is high, pick the winner.
  - If only one is requesting, it wins.
  - If both are requesting, the port not served last wins (round-robin; after reset, port 0).
  - On the same edge: latch addr and op into o_addr/o_controlreg, set o_owner, pulse o_ackN, go to ISSUE.
  - A request seen in cycle N gives o_ack and the command on o_controlreg in cycle N+1.
- ISSUE:
  - o_controlreg holds READ/WRITE and o_addr is stable.
  - The timeout counter increments each cycle.
  - On i_write_statusreg=1: latch i_statusreg into o_status, drive o_controlreg=NOP, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no strobe: o_status=TIMEOUT_STATUS, o_controlreg=NOP, go to DONE.
  - If the strobe and timeout occur in the same cycle, the strobe wins and the real status is reported.
- DONE:
  - Pulse o_doneN (owner only) for exactly 1 cycle; o_status is valid in that same cycle.
  - Update the round-robin pointer to the owner.
  - Go to GAP, or directly to IDLE if GAP_CYCLES=0.
- GAP: hold NOP for GAP_CYCLES cycles, then IDLE.
- i_write_statusreg pulses outside ISSUE are ignored and o_status is unchanged.
- Requests are ignored outside IDLE; requesters keep i_req high until ack.
- A deasserted i_req before ack withdraws the request with no side effects.
- Minimum request-to-request spacing: 1 (IDLE) + 1 (ISSUE minimum) + 1 (DONE) + GAP_CYCLES cycles.
- Counter width: 24 bits, saturating; never wraps.

Decomposition:
- Shared package sd_pkg:
  - ctrlreg codes CTRL_NOP=8'd0, CTRL_READ=8'd1, CTRL_WRITE=8'd2
  - state encoding (2-bit IDLE/ISSUE/DONE/GAP)
  - default TIMEOUT_STATUS
- One sub-module, sd_rr_arbiter:
  - purely combinational 2-way round-robin picker
  - inputs: req[1:0], last
  - outputs: grant[1:0], grant_idx
- Everything else lives in sd_request_arbiter.

Test Plan:
- Single read: i_req0=1, i_wr0=0, i_addr0=32'h0000_0010.
  - o_ack0 next cycle, o_controlreg=1, o_addr=32'h10.
  - Strobe with i_statusreg=8'h00 after 50 cycles: o_done0 one cycle later with o_status=0x00, then o_controlreg=0 for 4 cycles.
- Contention: i_req0 and i_req1 high in the same cycle after reset.
  - Port 0 is served first, then port 1 (write, o_controlreg=2, addr from i_addr1).
  - Grant order 0,1,0,1 while both stay requesting.
- Timeout: TIMEOUT_CYCLES=100, no strobe.
  - o_done1 is 100 cycles after the command; o_status=8'hFF; o_controlreg returns to 0.
- Simultaneous strobe and timeout: strobe at the timeout cycle with i_statusreg=8'h05 -> o_status=8'h05.
- Stray strobe in IDLE with i_statusreg=8'h33 -> no done pulse, o_status unchanged.
- Reset mid-ISSUE: assert i_rst_n=0 during a READ.
  - o_controlreg=0 asynchronously, no o_done.
  - After release, a new i_req1 is served first-come (port 0 idle).
